eth_tx_pkt_loader: RTL and testbench

Upstream feeder for the Ethernet RMII transmit controller. It accepts one payload frame per transaction on a byte-wide valid/ready stream and writes it into the TX byte FIFO. It zero-pads short frames to the Ethernet minimum payload and truncates oversize frames. Once the complete frame is buffered and the controller is idle, it pulses `Eth_Pkt_Rdy`. It holds off the next frame until the controller has drained the FIFO, which keeps `Fifo_Empty` meaningful as the end-of-data marker for the controller.

---
 rtl/eth_tx_pkt_loader.sv | 167 ++++++++++++++++
 tb/tb_eth_tx_pkt_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_pkt_loader.sv
// ---------------------------------------------------------------------------
// eth_tx_pkt_loader
//
// Feeds the Ethernet RMII TX byte FIFO from a byte-wide valid/ready stream,
// one payload frame per transaction. Short frames are zero-padded up to
// pMIN_PAYLOAD bytes. Frames longer than pMAX_PAYLOAD are truncated: the
// excess bytes are accepted and dropped. Once a frame is fully buffered and
// the TX controller is idle, the loader pulses Eth_Pkt_Rdy. It then waits for
// the controller to finish the frame before it accepts the next one, so the
// FIFO running empty always means "end of frame" to the controller.
//
// Ports
//   Clk          system clock (shared with the TX controller and the FIFO)
//   Rst          synchronous, active-high reset
//   S_Data       payload byte
//   S_Valid      S_Data is valid
//   S_Last       current byte is the last byte of the frame
//   S_Ready      loader accepts a byte this cycle (combinational)
//   Fifo_Full    TX FIFO full flag
//   Fifo_Wr      FIFO write strobe (combinational)
//   Fifo_Din     FIFO write data (combinational)
//   Tx_En        high while the TX controller is sending a frame
//   Eth_Pkt_Rdy  one-cycle pulse: frame buffered, start transmission
//   Pkt_Len      payload bytes written for the last frame, padding included
//   Ovf_Err      one-cycle pulse: the frame exceeded pMAX_PAYLOAD
// ---------------------------------------------------------------------------
module eth_tx_pkt_loader #(
  parameter int pMIN_PAYLOAD = 46,
  parameter int pMAX_PAYLOAD = 1500,
  parameter int pLEN_W       = 11
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        S_Data,
  input  logic              S_Valid,
  input  logic              S_Last,
  output logic              S_Ready,
  input  logic              Fifo_Full,
  output logic              Fifo_Wr,
  output logic [7:0]        Fifo_Din,
  input  logic              Tx_En,
  output logic              Eth_Pkt_Rdy,
  output logic [pLEN_W-1:0] Pkt_Len,
  output logic              Ovf_Err
);

  localparam logic [pLEN_W-1:0] LP_MIN = pLEN_W'(pMIN_PAYLOAD);
  localparam logic [pLEN_W-1:0] LP_MAX = pLEN_W'(pMAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    DISCARD,
    READY,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t            r_state;
  logic [pLEN_W-1:0] r_cnt;
  logic              r_pkt_rdy;
  logic              r_ovf;
  logic [pLEN_W-1:0] r_pkt_len;

  logic              w_in_load;
  logic              w_in_pad;
  logic              w_in_discard;
  logic              w_s_ready;
  logic              w_accept;
  logic [pLEN_W-1:0] w_cnt_inc;

  assign w_in_load    = (r_state == LOAD);
  assign w_in_pad     = (r_state == PAD);
  assign w_in_discard = (r_state == DISCARD);

  // LOAD is back-pressured by the FIFO. DISCARD throws bytes away, so it
  // never stalls the source.
  assign w_s_ready = (w_in_load & ~Fifo_Full) | w_in_discard;
  assign w_accept  = S_Valid & w_s_ready;

  // cnt never exceeds pMAX_PAYLOAD: LOAD leaves at the pMAX-th write and PAD
  // stops at pMIN, so this increment cannot wrap.
  assign w_cnt_inc = r_cnt + 1'b1;

  // Write in the accept cycle (zero latency). Pad writes are gated only by
  // Fifo_Full. Both paths keep Fifo_Wr low while the FIFO is full.
  assign S_Ready  = w_s_ready;
  assign Fifo_Wr  = (w_in_load & S_Valid & ~Fifo_Full) | (w_in_pad & ~Fifo_Full);
  assign Fifo_Din = w_in_load ? S_Data : 8'h00;

  assign Eth_Pkt_Rdy = r_pkt_rdy;
  assign Pkt_Len     = r_pkt_len;
  assign Ovf_Err     = r_ovf;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pkt_rdy <= 1'b0;
      r_ovf     <= 1'b0;
      r_pkt_len <= '0;
    end else begin
      // Both flags are one-cycle pulses. They fall back to 0 unless set below.
      r_pkt_rdy <= 1'b0;
      r_ovf     <= 1'b0;

      case (r_state)
        IDLE: begin
          if (!Tx_En) begin
            r_state <= LOAD;
            r_cnt   <= '0;
          end
        end

        LOAD: begin
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (S_Last) begin
              r_state <= (w_cnt_inc >= LP_MIN) ? READY : PAD;
            end else if (w_cnt_inc == LP_MAX) begin
              // The frame is full but not finished. Drop the rest of it.
              // A frame that ends exactly on pMAX takes the S_Last path
              // above and is not an overflow.
              r_state <= DISCARD;
              r_ovf   <= 1'b1;
            end
          end
        end

        PAD: begin
          if (!Fifo_Full) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == LP_MIN) r_state <= READY;
          end
        end

        DISCARD: begin
          if (S_Valid && S_Last) r_state <= READY;
        end

        READY: begin
          r_pkt_len <= r_cnt;
          // Do not start while the controller is still busy.
          if (!Tx_En) begin
            r_pkt_rdy <= 1'b1;
            r_state   <= WAIT_START;
          end
        end

        // Hold off the next frame until the controller has picked this one
        // up and finished it, so that Fifo_Empty stays a clean end-of-frame
        // marker for the controller.
        WAIT_START: begin
          if (Tx_En) r_state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (!Tx_En) r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_pkt_loader.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_pkt_loader
//
// Scoreboard bench. Each frame pushes the FIFO bytes it should produce (data,
// then zero padding, truncated at MAX). A negedge monitor pops one entry per
// Fifo_Wr and compares it.
// ---------------------------------------------------------------------------
module tb_eth_tx_pkt_loader;

  localparam int MIN = 46;
  localparam int MAX = 1500;
  localparam int LW  = 11;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [7:0]    S_Data = 8'h00;
  logic          S_Valid = 1'b0;
  logic          S_Last = 1'b0;
  logic          S_Ready;
  logic          Fifo_Full = 1'b0;
  logic          Fifo_Wr;
  logic [7:0]    Fifo_Din;
  logic          Tx_En = 1'b0;
  logic          Eth_Pkt_Rdy;
  logic [LW-1:0] Pkt_Len;
  logic          Ovf_Err;

  eth_tx_pkt_loader #(
    .pMIN_PAYLOAD(MIN),
    .pMAX_PAYLOAD(MAX),
    .pLEN_W      (LW)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .S_Data     (S_Data),
    .S_Valid    (S_Valid),
    .S_Last     (S_Last),
    .S_Ready    (S_Ready),
    .Fifo_Full  (Fifo_Full),
    .Fifo_Wr    (Fifo_Wr),
    .Fifo_Din   (Fifo_Din),
    .Tx_En      (Tx_En),
    .Eth_Pkt_Rdy(Eth_Pkt_Rdy),
    .Pkt_Len    (Pkt_Len),
    .Ovf_Err    (Ovf_Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb[$];
  int rdy_cnt = 0;
  int ovf_cnt = 0;
  int ovf_cyc = 0;
  int first_acc, last_acc, max_acc, tx_fall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] dv(input int seed, input int i);
    return 8'(seed + i + 1);
  endfunction

  // Write monitor and pulse counters.
  always @(negedge Clk) begin
    chk("wr_gate", 32'(Fifo_Wr & Fifo_Full), 32'd0);
    if (Fifo_Wr) begin
      if (sb.size() == 0) chk("wr_unexpected", 32'(Fifo_Wr), 32'd0);
      else                chk("wr_data", 32'(Fifo_Din), 32'(sb.pop_front()));
    end
    if (Eth_Pkt_Rdy) rdy_cnt++;
    if (Ovf_Err) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
  end

  // Drive one frame. full_at: stall the FIFO for 5 cycles when byte full_at
  // is presented. rst_at: assert Rst together with byte rst_at and abandon
  // the frame.
  task automatic send_frame(input int n, input int seed, input int full_at, input int rst_at);
    int idx = 0;
    int guard = 0;
    int full_left = 5;
    int nwr = (n < MAX) ? n : MAX;
    if (rst_at >= 0) nwr = rst_at + 1;
    for (int i = 0; i < nwr; i++) sb.push_back(dv(seed, i));
    if (rst_at < 0)
      for (int i = n; i < MIN; i++) sb.push_back(8'h00);
    while (idx < n && guard < 5000) begin
      @(posedge Clk); #1;
      Fifo_Full = (idx == full_at) && (full_left > 0);
      Rst       = (idx == rst_at);
      S_Valid   = 1'b1;
      S_Data    = dv(seed, idx);
      S_Last    = (idx == n - 1);
      @(negedge Clk);
      guard++;
      if (Fifo_Full) begin
        full_left--;
        chk("full_srdy", 32'(S_Ready), 32'd0);
        chk("full_wr", 32'(Fifo_Wr), 32'd0);
      end else if (S_Ready) begin
        if (idx == 0) first_acc = cyc;
        if (idx == MAX - 1) max_acc = cyc;
        last_acc = cyc;
        idx++;
        if (Rst) break;
      end
    end
    if (rst_at < 0) chk("send_cnt", 32'(idx), 32'(n));
    @(posedge Clk); #1;
    S_Valid = 1'b0;
    S_Last  = 1'b0;
    Rst     = 1'b0;
    Fifo_Full = 1'b0;
  endtask

  task automatic pad_full(input int d);
    repeat (d) @(posedge Clk);
    #1 Fifo_Full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("padfull_wr", 32'(Fifo_Wr), 32'd0);
      chk("padfull_srdy", 32'(S_Ready), 32'd0);
    end
    @(posedge Clk); #1 Fifo_Full = 1'b0;
  endtask

  task automatic wait_rdy(input int exp_cyc, input bit chk_lat, input int exp_len);
    int guard = 0;
    do begin
      @(negedge Clk);
      guard++;
    end while (!Eth_Pkt_Rdy && guard < 200);
    if (!Eth_Pkt_Rdy) begin
      chk("rdy_timeout", 32'(Eth_Pkt_Rdy), 32'd1);
      return;
    end
    if (chk_lat) chk("rdy_lat", 32'(cyc), 32'(exp_cyc));
    chk("pkt_len", 32'(Pkt_Len), 32'(exp_len));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    @(negedge Clk);
    chk("rdy_width", 32'(Eth_Pkt_Rdy), 32'd0);
  endtask

  // TX controller: raise Tx_En, hold it for a few cycles, then drop it.
  task automatic tx_cycle(input int hold);
    @(posedge Clk); #1 Tx_En = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk("txen_srdy", 32'(S_Ready), 32'd0);
    end
    @(posedge Clk); #1 Tx_En = 1'b0;
    tx_fall = cyc;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 60000", cyc);
    $fatal(1);
  end

  initial begin
    int ovf0, rdy0;
    // Reset values
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_srdy", 32'(S_Ready), 32'd0);
    chk("rst_wr", 32'(Fifo_Wr), 32'd0);
    chk("rst_rdy", 32'(Eth_Pkt_Rdy), 32'd0);
    chk("rst_ovf", 32'(Ovf_Err), 32'd0);
    chk("rst_len", 32'(Pkt_Len), 32'd0);
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk) chk("idle_srdy", 32'(S_Ready), 32'd0);
    @(negedge Clk) chk("load_srdy", 32'(S_Ready), 32'd1);

    // 60-byte frame 0x01..0x3C
    ovf0 = ovf_cnt;
    send_frame(60, 0, -1, -1);
    chk("span60", 32'(last_acc - first_acc), 32'd59);
    wait_rdy(last_acc + 2, 1'b1, 60);
    chk("ovf60", 32'(ovf_cnt - ovf0), 32'd0);
    tx_cycle(6);

    // 10-byte frame, padded to MIN on consecutive cycles
    send_frame(10, 8'h40, -1, -1);
    chk("span10", 32'(last_acc - first_acc), 32'd9);
    wait_rdy(last_acc + (MIN - 10) + 2, 1'b1, MIN);
    tx_cycle(4);

    // 1600-byte frame: truncate at MAX, one Ovf_Err
    ovf0 = ovf_cnt;
    send_frame(1600, 8'h80, -1, -1);
    chk("span1600", 32'(last_acc - first_acc), 32'd1599);
    chk("ovf_cnt", 32'(ovf_cnt - ovf0), 32'd1);
    chk("ovf_lat", 32'(ovf_cyc), 32'(max_acc + 1));
    wait_rdy(last_acc + 2, 1'b1, MAX);
    tx_cycle(4);

    // Exactly MAX bytes: not an overflow
    ovf0 = ovf_cnt;
    send_frame(MAX, 8'h11, -1, -1);
    wait_rdy(last_acc + 2, 1'b1, MAX);
    chk("ovf_exact", 32'(ovf_cnt - ovf0), 32'd0);
    tx_cycle(4);

    // Fifo_Full for 5 cycles mid-frame
    send_frame(60, 8'h10, 25, -1);
    wait_rdy(0, 1'b0, 60);
    tx_cycle(4);

    // Fifo_Full for 5 cycles mid-pad: the pad stretches by 5 cycles
    send_frame(10, 8'h20, -1, -1);
    pad_full(3);
    wait_rdy(last_acc + (MIN - 10) + 5 + 2, 1'b1, MIN);
    tx_cycle(4);

    // Second frame offered while the first is still transmitting
    send_frame(50, 8'h30, -1, -1);
    wait_rdy(last_acc + 2, 1'b1, 50);
    fork
      tx_cycle(8);
    join_none
    send_frame(48, 8'h50, -1, -1);
    wait fork;
    chk("b2b_lat", 32'(first_acc), 32'(tx_fall + 2));
    wait_rdy(last_acc + 2, 1'b1, 48);
    tx_cycle(3);

    // Reset on byte 20 of a 60-byte frame
    rdy0 = rdy_cnt;
    send_frame(60, 8'h60, -1, 19);
    @(negedge Clk);
    chk("mrst_srdy", 32'(S_Ready), 32'd0);
    chk("mrst_wr", 32'(Fifo_Wr), 32'd0);
    chk("mrst_rdy", 32'(Eth_Pkt_Rdy), 32'd0);
    chk("mrst_ovf", 32'(Ovf_Err), 32'd0);
    chk("mrst_len", 32'(Pkt_Len), 32'd0);
    repeat (10) @(negedge Clk);
    chk("mrst_norb", 32'(rdy_cnt - rdy0), 32'd0);
    chk("mrst_sb", 32'(sb.size()), 32'd0);

    // Fresh 46-byte frame after the reset
    send_frame(46, 8'h70, -1, -1);
    chk("span46", 32'(last_acc - first_acc), 32'd45);
    wait_rdy(last_acc + 2, 1'b1, 46);
    tx_cycle(3);
    repeat (3) @(posedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
